ama_serial_adder: RTL
=====================

Name: ama_serial_adder

Overview:
- Bit-serial, LSB-first approximate adder built from the registered approximate half-adder cell behaviour (sum = a^b, cout = a&b), extended with an exact full-adder upper region.
- Sits directly upstream of result consumers in the adder datapath.
- Accepts WIDTH-bit operand pairs over a valid/ready handshake, processes one bit per clock, and returns a WIDTH+1-bit result over a valid/ready handshake.

Parameters:
- WIDTH, 8, operand width in bits; must be ≥ 2.
- APPROX_BITS, 4, number of low-order bits computed approximately; legal range 0..WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH+1  sum; the MSB is the final carry.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, in_ready = 1, out_valid = 0, result = 0.
  - Internal shift registers, bit counter and carry register all = 0.
  - Reset takes effect immediately, including mid-RUN or in DONE; any in-flight operation is discarded and no result is emitted.
- State machine, one-hot or encoded (implementer's choice):
  - IDLE: in_ready = 1, out_valid = 0. When in_valid & in_ready at a rising edge: latch a and b into shift registers, counter = 0, carry = 0, go to RUN.
  - RUN: in_ready = 0, out_valid = 0. Each edge processes bit i = counter, shifts the operand registers right by one, and shifts the result bit into the result register.
    - When counter == WIDTH-1 on an edge, that edge also latches the final carry into result[WIDTH] and moves to DONE.
  - DONE: out_valid = 1. result is held stable while out_valid = 1 and out_ready = 0. When out_ready is high at an edge, go to IDLE, and out_valid falls on that edge.
- Per-bit arithmetic:
  - Bit i < APPROX_BITS: s_i = a_i ^ b_i. The a_i & b_i carry is discarded, except at i = APPROX_BITS-1, where it is stored as the carry into bit APPROX_BITS. Carry into the approximate region is always 0.
  - Bit i ≥ APPROX_BITS: exact full add, s_i = a_i ^ b_i ^ c and c' = maj(a_i, b_i, c).
  - result[WIDTH] = carry after bit WIDTH-1.
  - APPROX_BITS = 0 gives an exact adder.
  - APPROX_BITS = WIDTH gives result[WIDTH] = a[WIDTH-1] & b[WIDTH-1].
- Timing:
  - Latency: operands accepted at edge k, out_valid high after edge k+WIDTH.
  - Minimum spacing between accepts is WIDTH+2 cycles. in_ready is high only in IDLE; there is no accept in DONE, even if out_ready and in_valid are high together.
  - in_valid held high while not ready: operands are ignored until the IDLE handshake. a and b are sampled only on the accept edge; changes during RUN have no effect.
- Counter width: $clog2(WIDTH)+1; no wrap beyond WIDTH-1.

Test Plan:
- WIDTH=8, APPROX_BITS=4; a=0x0F, b=0x01 → result=0x00E, out_valid exactly 8 cycles after the accept edge (exact sum would be 0x010).
- WIDTH=8, APPROX_BITS=4; a=0xFF, b=0xFF → result=0x1F0 (boundary carry from bit 3 enters the exact region); a=0x08, b=0x08 → result=0x010.
- WIDTH=8, APPROX_BITS=0; a=0xFF, b=0x01 → result=0x100. APPROX_BITS=8; a=0x80, b=0x80 → result=0x100; a=0x7F, b=0x01 → result=0x07E.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result and out_valid stable, in_ready=0, new in_valid ignored. Raise out_ready → out_valid=0 next edge, in_ready=1, and the next operand pair is accepted correctly.
- Reset mid-operation: assert rst_n=0 at bit 3 of a RUN → outputs immediately return to reset values with no clock edge. After release, a fresh a=0x01, b=0x02 gives result=0x003.
- Back-to-back stream of 4 random operand pairs against a reference model of the per-bit rule, with random out_ready stalls → every result matches, and none are dropped or duplicated.

Source files
------------

// File: rtl/ama_serial_adder.sv
// Bit-serial, LSB-first approximate adder.
// The low APPROX_BITS bits use a carry-free XOR sum; the only carry that survives the
// approximate region is a&b of its top bit, which feeds an exact ripple region above it.
// One operand bit is processed per clock; the WIDTH+1-bit result is returned over a
// valid/ready handshake.
module ama_serial_adder #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_BITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt     = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] ApproxCnt   = CntW'(APPROX_BITS);
    // Only consulted while inside the approximate region, so APPROX_BITS == 0 never uses it.
    localparam logic [CntW-1:0] BoundaryCnt = CntW'(APPROX_BITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [WIDTH:0]    res_q, res_d;

    logic bit_a;
    logic bit_b;
    logic in_approx;
    logic sum_bit;
    logic carry_out;

    // Per-bit sum and carry for the bit currently at the bottom of the shift registers.
    always_comb begin
        bit_a     = a_q[0];
        bit_b     = b_q[0];
        in_approx = (cnt_q < ApproxCnt);
        sum_bit   = 1'b0;
        carry_out = 1'b0;
        if (in_approx) begin
            sum_bit   = bit_a ^ bit_b;
            // Carries inside the approximate region are dropped, except at its top bit.
            carry_out = (cnt_q == BoundaryCnt) ? (bit_a & bit_b) : 1'b0;
        end else begin
            sum_bit   = bit_a ^ bit_b ^ carry_q;
            carry_out = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);
        end
    end

    // Next-state logic: accept in IDLE, shift one bit per cycle in RUN, hold in DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        res_d   = res_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    res_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d                = {1'b0, a_q[WIDTH-1:1]};
                b_d                = {1'b0, b_q[WIDTH-1:1]};
                carry_d            = carry_out;
                res_d[WIDTH-1:0]   = {sum_bit, res_q[WIDTH-1:1]};
                if (cnt_q == LastCnt) begin
                    res_d[WIDTH] = carry_out;
                    state_d      = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = res_q;

endmodule
